// File: rtl/ds1302_reader.sv
// DS1302 periodic read master: polls seconds/minutes/hours over the
// 3-wire bus and publishes one masked BCD snapshot per sequence.
module ds1302_reader #(
  parameter int HALF     = 50,
  parameter int CE_GAP   = 200,
  parameter int POLL_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       ce,
  output logic       sclk,
  output logic       io_out,
  output logic       io_oe,
  input  logic       io_in,
  output logic [7:0] second_out,
  output logic [7:0] minute_out,
  output logic [7:0] hour_out,
  output logic       data_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_READ,
    S_GAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic [31:0] r_poll;
  logic [3:0]  r_ph;
  logic [1:0]  r_idx;
  logic [6:0]  r_sh;
  logic [6:0]  r_sec;
  logic [6:0]  r_min;
  logic        w_hend;
  logic        w_gend;
  logic        w_req;
  logic        w_step;
  logic        w_samp;
  logic        w_last;
  logic [7:0]  w_cmd;
  logic [7:0]  w_byte;

  assign w_hend = (r_cnt == 32'(HALF - 1));
  assign w_gend = (r_cnt == 32'(CE_GAP - 1));
  assign w_req  = (r_poll == '0);
  assign w_cmd  = 8'h81 | {5'b0, r_idx, 1'b0};
  assign w_byte = {io_in, r_sh};
  // even half-phases of READ are the sclk-low phases
  assign w_samp = (r_state == S_READ) && w_hend && !r_ph[0];
  assign w_last = w_samp && (r_ph == 4'd14);

  always_comb begin
    w_next = r_state;
    w_step = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) w_next = S_SETUP;
      end
      S_SETUP: begin
        if (w_hend) begin
          w_step = 1'b1;
          w_next = S_CMD;
        end
      end
      S_CMD: begin
        if (w_hend) begin
          w_step = 1'b1;
          if (r_ph == 4'd15) w_next = S_READ;
        end
      end
      S_READ: begin
        if (w_hend) begin
          w_step = 1'b1;
          if (r_ph == 4'd14) w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_gend) begin
          w_step = 1'b1;
          w_next = (r_idx == 2'd2) ? S_IDLE : S_SETUP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ce     = 1'b0;
    sclk   = 1'b0;
    io_oe  = 1'b0;
    io_out = 1'b0;
    unique case (r_state)
      S_SETUP: ce = 1'b1;
      S_CMD: begin
        ce     = 1'b1;
        sclk   = r_ph[0];
        io_oe  = 1'b1;
        io_out = w_cmd[r_ph[3:1]];
      end
      S_READ: begin
        ce   = 1'b1;
        sclk = r_ph[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_poll  <= '0;
      r_ph    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_poll  <= (r_poll == 32'(POLL_DIV - 1)) ? '0 : r_poll + 32'd1;
      r_cnt   <= (w_step || r_state == S_IDLE) ? '0 : r_cnt + 32'd1;
      if (w_step) r_ph <= (w_next == r_state) ? r_ph + 4'd1 : 4'd0;
      if (r_state == S_IDLE) r_idx <= '0;
      else if (r_state == S_GAP && w_gend) r_idx <= r_idx + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh       <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      second_out <= '0;
      minute_out <= '0;
      hour_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (w_samp) r_sh <= w_byte[7:1];
      if (r_state == S_IDLE && w_req) busy <= 1'b1;
      if (w_last) begin
        unique case (r_idx)
          2'd0: r_sec <= w_byte[6:0];
          2'd1: r_min <= w_byte[6:0];
          default: begin
            second_out <= {1'b0, r_sec};
            minute_out <= {1'b0, r_min};
            hour_out   <= {2'b00, w_byte[5:0]};
            data_valid <= 1'b1;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ds1302_reader.sv
// Bench for ds1302_reader: DS1302 bus model with random register
// contents, command/timing/masking/atomicity and async-reset checks.
module tb_ds1302_reader;

  localparam int HALF     = 2;
  localparam int CE_GAP   = 5;
  localparam int POLL_DIV = 500;
  localparam int LAT      = 96 * HALF + 2 * CE_GAP;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       sclk;
  logic       io_out;
  logic       io_oe;
  logic       io_in;
  logic [7:0] second_out;
  logic [7:0] minute_out;
  logic [7:0] hour_out;
  logic       data_valid;
  logic       busy;

  ds1302_reader #(
    .HALF    (HALF),
    .CE_GAP  (CE_GAP),
    .POLL_DIV(POLL_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .sclk      (sclk),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .io_in     (io_in),
    .second_out(second_out),
    .minute_out(minute_out),
    .hour_out  (hour_out),
    .data_valid(data_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // bus model state
  int         cyc = 0;
  int         t_start = 0;
  int         seqn = 0;
  int         dv_cnt = 0;
  int         tnum = 0;
  int         nb = 0;
  int         rb = 0;
  bit         have_start = 0;
  bit         p_ce = 0;
  bit         p_sclk = 0;
  bit         p_dv = 0;
  bit         oe_bad = 0;
  bit         cmd_oe_bad = 0;
  logic [7:0] cmd;
  logic [7:0] dat [3];
  logic [23:0] snap = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      p_ce = 0; p_sclk = 0; p_dv = 0;
      nb = 0; rb = 0; tnum = 0;
      have_start = 0; snap = '0; io_in = 1'b0;
    end else begin
      if (ce && !p_ce) begin
        check("busy_at_ce", busy, 1);
        check("hold", {second_out, minute_out, hour_out}, snap);
        if (tnum == 0) begin
          if (have_start) check("poll_period", cyc - t_start, POLL_DIV);
          have_start = 1;
          t_start = cyc;
          if (seqn == 0) begin
            dat[0] = 8'h59; dat[1] = 8'h59; dat[2] = 8'h23;
          end else if (seqn == 1) begin
            dat[0] = 8'hD9; dat[1] = 8'h87; dat[2] = 8'hD2;
          end else begin
            for (int k = 0; k < 3; k++) dat[k] = 8'($urandom);
          end
          seqn++;
        end
        nb = 0; rb = 0; cmd = '0; oe_bad = 0; cmd_oe_bad = 0;
      end
      if (ce && sclk && !p_sclk && nb < 8) begin
        cmd[nb] = io_out;
        if (!io_oe) cmd_oe_bad = 1;
        nb++;
        if (nb == 8) begin
          check("cmd", cmd, 32'h81 + 32'(2 * tnum));
          check("cmd_oe", cmd_oe_bad, 0);
        end
      end else if (ce && !sclk && p_sclk && nb == 8 && rb < 8) begin
        io_in = dat[tnum][rb];
        rb++;
      end
      if (ce && nb == 8 && rb > 0 && io_oe) oe_bad = 1;
      if (data_valid) begin
        check("dv_pulse", p_dv, 0);
        check("latency", cyc - t_start, LAT);
        check("busy_at_dv", busy, 0);
        snap = {dat[0] & 8'h7F, dat[1] & 8'h7F, dat[2] & 8'h3F};
        check("sec", second_out, snap[23:16]);
        check("min", minute_out, snap[15:8]);
        check("hr", hour_out, snap[7:0]);
        dv_cnt++;
      end
      if (!ce && p_ce) begin
        check("read_oe", oe_bad, 0);
        check("read_bits", rb, 8);
        tnum = (tnum + 1) % 3;
      end
      p_ce = ce; p_sclk = sclk; p_dv = data_valid;
    end
  end

  task automatic wait_dv(input int n);
    int c;
    c = 0;
    while (dv_cnt < n && c < (n + 2) * POLL_DIV) begin
      @(negedge clk);
      c++;
    end
    check("dv_timeout", dv_cnt >= n, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pins"}, {ce, sclk, io_oe, io_out}, 0);
    check({tag, "_flags"}, {data_valid, busy}, 0);
    check({tag, "_time"}, {second_out, minute_out, hour_out}, 0);
  endtask

  initial begin
    int c;
    int base;
    rst_n = 1'b0;
    io_in = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ce_first_clk", ce, 1);
    wait_dv(4);

    c = 0;
    while (!(tnum == 1 && nb == 3) && c < 2 * POLL_DIV) begin
      @(negedge clk);
      c++;
    end
    check("reach_min_bit4", (tnum == 1 && nb == 3), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ce_after_rst", ce, 1);
    base = dv_cnt;
    wait_dv(base + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
